// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO scheduler: drain states,
// FIFO depth helper and the default byte width.
`default_nettype none

package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } drain_state_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_sched_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the losing requester
// whenever the granted byte is accepted.
`default_nettype none

module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       sel_o
);

  logic rr_q;
  logic rr_d;
  logic w_sel;

  always_comb begin
    w_sel = req_i[1];
    if (req_i[0] && req_i[1]) begin
      w_sel = rr_q;
    end
  end

  assign gnt_o = {req_i[1] & w_sel, req_i[0] & ~w_sel};
  assign sel_o = w_sel;
  assign rr_d  = accept_i ? ~w_sel : rr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_sched.sv
// Arbitrates two byte producers into the shared TX FIFO and drains it into
// the UART shifter, using the FIFO's empty-bypass for zero-latency pass-through.
`default_nettype none

module uart_tx_fifo_sched
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AF_THRESH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  p0_valid_i,
  input  logic [DATA_WIDTH-1:0] p0_data_i,
  output logic                  p0_ready_o,
  input  logic                  p1_valid_i,
  input  logic [DATA_WIDTH-1:0] p1_data_i,
  output logic                  p1_ready_o,
  output logic                  fifo_enQ_o,
  output logic                  fifo_deQ_o,
  output logic [DATA_WIDTH-1:0] fifo_data_in_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_out_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_count_i,
  output logic                  fifo_reset_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_start_o,
  input  logic                  tx_ready_i,
  output logic                  almost_full_o,
  output logic                  full_o
);

  localparam int unsigned       DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam int unsigned       AF_EFF  = (AF_THRESH > DEPTH) ? DEPTH : AF_THRESH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_EFF);

  drain_state_e          state_q, state_d;
  logic                  init_q;
  logic                  hold_q, hold_d;
  logic                  af_q, af_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic [1:0]            w_req, w_gnt, w_ready;
  logic                  w_sel, w_full, w_block, w_open, w_accept;
  logic                  w_deq, w_start;
  logic [ADDR_WIDTH:0]   w_free;

  assign w_full  = (fifo_count_i == DEPTH_C);
  assign w_free  = DEPTH_C - fifo_count_i;
  assign af_d    = (w_free <= AF_C);

  // init_q keeps the first post-reset cycle quiet so the FIFO reset pulse
  // follows reset release instead of overlapping it.
  assign w_block = init_q | flush_i | (state_q == ST_FLUSH);
  assign w_open  = ~w_full & ~hold_q & ~w_block;
  assign w_req   = {p1_valid_i, p0_valid_i};

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (w_req),
    .accept_i (w_accept),
    .gnt_o    (w_gnt),
    .sel_o    (w_sel)
  );

  assign w_ready  = w_gnt & {2{w_open}};
  assign w_accept = |w_ready;

  always_comb begin
    state_d   = state_q;
    hold_d    = 1'b0;
    tx_data_d = tx_data_q;
    w_deq     = 1'b0;
    w_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Enqueue and dequeue may coincide only on an empty FIFO (bypass),
        // otherwise a pending write wins once and then yields via hold.
        if (tx_ready_i && (fifo_empty_i ? w_accept : ~w_accept)) begin
          w_deq     = 1'b1;
          tx_data_d = fifo_data_out_i;
          state_d   = ST_START;
        end
        hold_d = tx_ready_i & ~fifo_empty_i & w_accept;
      end
      ST_START: begin
        w_start = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush_i || init_q) begin
      state_d   = ST_FLUSH;
      hold_d    = 1'b0;
      tx_data_d = tx_data_q;
      w_deq     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      init_q    <= 1'b1;
      hold_q    <= 1'b0;
      af_q      <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      init_q    <= 1'b0;
      hold_q    <= hold_d;
      af_q      <= af_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign p0_ready_o     = w_ready[0];
  assign p1_ready_o     = w_ready[1];
  assign fifo_enQ_o     = w_accept;
  assign fifo_deQ_o     = w_deq;
  assign fifo_data_in_o = w_sel ? p1_data_i : p0_data_i;
  assign fifo_reset_o   = (state_q == ST_FLUSH);
  assign tx_data_o      = tx_data_q;
  assign tx_start_o     = w_start;
  assign almost_full_o  = af_q;
  assign full_o         = w_full;

endmodule

`default_nettype wire
